// File: rtl/apb_cmd_sequencer.sv
// Command FIFO feeding a single-outstanding APB master request interface.
// Reads return a response (or a timeout abort); writes complete silently.
module apb_cmd_sequencer #(
  parameter int DATA    = 32,
  parameter int ADDR    = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   pclk,
  input  logic                   presetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_rw,
  input  logic [ADDR-1:0]        cmd_addr,
  input  logic [DATA-1:0]        cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA-1:0]        rsp_rdata,
  output logic                   rsp_err,
  output logic                   transfer,
  output logic                   rw,
  output logic [ADDR-1:0]        addr_in,
  output logic [DATA-1:0]        data_in,
  input  logic [DATA-1:0]        prdata,
  input  logic                   xfer_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int EW = 1 + ADDR + DATA;

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t          state_reg, state_next;
  logic [EW-1:0]   fifo_mem [DEPTH];
  logic [EW-1:0]   head;
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]   level_reg;
  logic            ready_reg;
  logic [TW-1:0]   tmo_reg;
  logic            rw_reg;
  logic [ADDR-1:0] addr_reg;
  logic [DATA-1:0] data_reg;
  logic [DATA-1:0] rdata_reg;
  logic            err_reg;
  logic            push, pop, finish;

  // ready_reg keeps cmd_ready low throughout reset and for the reset cycle itself
  assign cmd_ready = ready_reg & (level_reg != LW'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign head      = fifo_mem[rd_ptr_reg];

  always_ff @(posedge pclk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {cmd_rw, cmd_addr, cmd_wdata};
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Completion wins over timeout when both land in the same cycle.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (level_reg != '0) begin
          pop        = 1'b1;
          state_next = XFER;
        end
      end
      XFER: begin
        if (xfer_done || (tmo_reg == TW'(TIMEOUT - 1))) begin
          finish     = 1'b1;
          state_next = rw_reg ? IDLE : RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      ready_reg  <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      tmo_reg    <= '0;
      rw_reg     <= 1'b0;
      addr_reg   <= '0;
      data_reg   <= '0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      ready_reg <= 1'b1;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg                   <= rd_ptr_reg + PW'(1);
        {rw_reg, addr_reg, data_reg} <= head;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
      if (pop) begin
        tmo_reg <= '0;
      end else if (state_reg == XFER) begin
        tmo_reg <= tmo_reg + TW'(1);
      end
      // Aborted reads report zero data with the error flag set.
      if (finish && !rw_reg) begin
        rdata_reg <= xfer_done ? prdata : '0;
        err_reg   <= ~xfer_done;
      end
    end
  end

  assign transfer  = (state_reg == XFER);
  assign rsp_valid = (state_reg == RESP);
  assign busy      = (state_reg != IDLE) || (level_reg != '0);
  assign level     = level_reg;
  assign rw        = rw_reg;
  assign addr_in   = addr_reg;
  assign data_in   = data_reg;
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Bench for apb_cmd_sequencer: transaction-level queue model checked every
// cycle, plus directed scenarios with hand-computed cycle expectations.
module tb_apb_cmd_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        pclk, presetn;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        transfer, rw;
  logic [31:0] addr_in, data_in, prdata;
  logic        xfer_done, busy;
  logic [2:0]  level;

  apb_cmd_sequencer #(.DATA(32), .ADDR(32), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .transfer(transfer), .rw(rw), .addr_in(addr_in), .data_in(data_in),
    .prdata(prdata), .xfer_done(xfer_done), .busy(busy), .level(level)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: the queue is the FIFO contents; one command may
  // be in flight, followed by an optional pending read response.
  typedef struct {
    logic        rw;
    logic [31:0] a;
    logic [31:0] d;
  } cmd_t;

  cmd_t        mq[$];
  cmd_t        mcur;
  bit          m_ready, m_xfer, m_resp, m_acc;
  logic [31:0] m_rdata;
  logic        m_err;
  int          m_elapsed;

  always @(posedge pclk) begin
    if (!presetn) begin
      mq.delete();
      m_ready = 1'b0; m_xfer = 1'b0; m_resp = 1'b0;
      m_rdata = '0; m_err = 1'b0; m_elapsed = 0;
    end else begin
      m_acc = cmd_valid && m_ready && (mq.size() != DEPTH);
      if (m_xfer) begin
        m_elapsed++;
        if (xfer_done || m_elapsed == TIMEOUT) begin
          m_xfer = 1'b0;
          if (!mcur.rw) begin
            m_resp  = 1'b1;
            m_rdata = xfer_done ? prdata : 32'h0;
            m_err   = !xfer_done;
          end
        end
      end else if (m_resp) begin
        if (rsp_ready) m_resp = 1'b0;
      end else if (mq.size() > 0) begin
        mcur      = mq.pop_front();
        m_xfer    = 1'b1;
        m_elapsed = 0;
      end
      if (m_acc) mq.push_back('{cmd_rw, cmd_addr, cmd_wdata});
      m_ready = 1'b1;
    end
  end

  logic [31:0] ilog[$];
  bit          prev_tr = 1'b0;

  always @(negedge pclk) begin
    if (transfer && !prev_tr) ilog.push_back(addr_in);
    prev_tr = transfer;
    if (chk_en) begin
      chk("m_transfer", 64'(transfer), 64'(m_xfer));
      chk("m_cmd_ready", 64'(cmd_ready), 64'(m_ready && (mq.size() != DEPTH)));
      chk("m_level", 64'(level), 64'(mq.size()));
      chk("m_busy", 64'(busy), 64'(m_xfer || m_resp || (mq.size() != 0)));
      chk("m_rsp_valid", 64'(rsp_valid), 64'(m_resp));
      if (m_xfer) begin
        chk("m_rw", 64'(rw), 64'(mcur.rw));
        chk("m_addr_in", 64'(addr_in), 64'(mcur.a));
        chk("m_data_in", 64'(data_in), 64'(mcur.d));
      end
      if (m_resp) begin
        chk("m_rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
        chk("m_rsp_err", 64'(rsp_err), 64'(m_err));
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Presents one command in the current cycle; returns one cycle later.
  task automatic send(input logic r, input logic [31:0] a, input logic [31:0] d);
    chk("send_ready", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_rw = r; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=hang want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  idx;
    bit  r;
    presetn = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; xfer_done = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_transfer", 64'(transfer), 64'(0));
    chk("rst_rw", 64'(rw), 64'(0));
    chk("rst_addr_in", 64'(addr_in), 64'(0));
    chk("rst_data_in", 64'(data_in), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_rsp_err", 64'(rsp_err), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    presetn = 1'b1;
    tick();
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));

    // Single write, done in cycle 4
    send(1'b1, 32'h10, 32'hA5A5A5A5);
    chk("wr_c1_transfer", 64'(transfer), 64'(0));
    tick();
    chk("wr_c2_transfer", 64'(transfer), 64'(1));
    chk("wr_c2_rw", 64'(rw), 64'(1));
    chk("wr_c2_addr", 64'(addr_in), 64'h10);
    chk("wr_c2_data", 64'(data_in), 64'hA5A5A5A5);
    tick();
    chk("wr_c3_transfer", 64'(transfer), 64'(1));
    tick();
    chk("wr_c4_transfer", 64'(transfer), 64'(1));
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    chk("wr_c5_transfer", 64'(transfer), 64'(0));
    chk("wr_c5_rsp_valid", 64'(rsp_valid), 64'(0));
    tick();
    chk("wr_c6_busy", 64'(busy), 64'(0));

    // Read with backpressure, write queued behind it
    send(1'b0, 32'h20, 32'h0);
    send(1'b1, 32'h24, 32'h55);
    chk("rd_c2_transfer", 64'(transfer), 64'(1));
    chk("rd_c2_addr", 64'(addr_in), 64'h20);
    xfer_done = 1'b1; prdata = 32'hDEADBEEF;
    tick();
    xfer_done = 1'b0; prdata = 32'hBAD0BAD0;
    for (int k = 0; k < 3; k++) begin
      chk("rd_hold_valid", 64'(rsp_valid), 64'(1));
      chk("rd_hold_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
      chk("rd_hold_err", 64'(rsp_err), 64'(0));
      chk("rd_hold_transfer", 64'(transfer), 64'(0));
      tick();
    end
    rsp_ready = 1'b1;
    chk("rd_r_valid", 64'(rsp_valid), 64'(1));
    tick();
    rsp_ready = 1'b0;
    chk("rd_r1_valid", 64'(rsp_valid), 64'(0));
    chk("rd_r1_transfer", 64'(transfer), 64'(0));
    tick();
    chk("rd_r2_transfer", 64'(transfer), 64'(1));
    chk("rd_r2_addr", 64'(addr_in), 64'h24);
    chk("rd_r2_data", 64'(data_in), 64'h55);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    tick();

    // Timeout on a read
    send(1'b0, 32'h30, 32'h0);
    tick();
    n = 0;
    while (transfer && n < 40) begin
      n++;
      tick();
    end
    chk("tmo_cycles", 64'(n), 64'(16));
    chk("tmo_valid", 64'(rsp_valid), 64'(1));
    chk("tmo_err", 64'(rsp_err), 64'(1));
    chk("tmo_rdata", 64'(rsp_rdata), 64'(0));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("tmo_cleared", 64'(rsp_valid), 64'(0));

    // Done on the 16th XFER cycle beats timeout
    send(1'b0, 32'h34, 32'h0);
    tick();
    repeat (15) tick();
    chk("dvt_c17_transfer", 64'(transfer), 64'(1));
    xfer_done = 1'b1; prdata = 32'h1234;
    tick();
    xfer_done = 1'b0;
    chk("dvt_valid", 64'(rsp_valid), 64'(1));
    chk("dvt_err", 64'(rsp_err), 64'(0));
    chk("dvt_rdata", 64'(rsp_rdata), 64'h1234);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();

    // Full FIFO, then drain in order
    ilog.delete();
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 32'(idx * 4); cmd_wdata = 32'(32'h100 + idx);
      r = cmd_ready;
      tick();
      if (r) idx++;
    end
    chk("full_accepted", 64'(idx), 64'(5));
    chk("full_level", 64'(level), 64'(4));
    chk("full_cmd_ready", 64'(cmd_ready), 64'(0));
    xfer_done = 1'b1;
    n = 0;
    while ((idx < 6 || busy) && n < 60) begin
      cmd_valid = (idx < 6); cmd_addr = 32'(idx * 4); cmd_wdata = 32'(32'h100 + idx);
      r = cmd_ready;
      tick();
      if (r && idx < 6) idx++;
      n++;
    end
    cmd_valid = 1'b0; xfer_done = 1'b0;
    chk("full_drain_bound", 64'(n < 60), 64'(1));
    chk("full_issued", 64'(ilog.size()), 64'(6));
    for (int k = 0; k < ilog.size(); k++) chk("full_order", 64'(ilog[k]), 64'(k * 4));
    tick();

    // Reset mid-XFER with two commands queued
    send(1'b0, 32'h40, 32'h0);
    send(1'b0, 32'h44, 32'h0);
    send(1'b0, 32'h48, 32'h0);
    chk("mid_transfer", 64'(transfer), 64'(1));
    chk("mid_level", 64'(level), 64'(2));
    presetn = 1'b0;
    tick();
    presetn = 1'b1;
    chk("mid_rst_transfer", 64'(transfer), 64'(0));
    chk("mid_rst_level", 64'(level), 64'(0));
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'(0));
    tick();
    chk("mid_rel_cmd_ready", 64'(cmd_ready), 64'(1));
    repeat (3) tick();
    chk("mid_quiet_transfer", 64'(transfer), 64'(0));
    chk("mid_quiet_rsp", 64'(rsp_valid), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_cmd_sequencer.md
APB_CMD_SEQUENCER -- requirements
Module: apb_cmd_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA, 32: data width.
- ADDR, 32: address width.
- DEPTH, 4: command FIFO entries, power of 2.
- TIMEOUT, 16: max cycles in XFER before abort, ≥2.

REQ-002 Ports (name, direction, width, meaning), one per line:
- pclk, in, 1: single clock, rising edge.
- presetn, in, 1: synchronous, active-low reset.
- cmd_valid, in, 1: host command valid.
- cmd_ready, out, 1: FIFO can accept.
- cmd_rw, in, 1: 1=write, 0=read.
- cmd_addr, in, ADDR: command address.
- cmd_wdata, in, DATA: write data.
- rsp_valid, out, 1: read response valid.
- rsp_ready, in, 1: host accepts response.
- rsp_rdata, out, DATA: read data.
- rsp_err, out, 1: response is a timeout abort.
- transfer, out, 1: request to APB master.
- rw, out, 1: to master, 1=write.
- addr_in, out, ADDR: to master.
- data_in, out, DATA: to master.
- prdata, in, DATA: read data from APB.
- xfer_done, in, 1: master access phase complete (psel&penable&pready).
- busy, out, 1: FSM not IDLE or FIFO non-empty.
- level, out, $clog2(DEPTH)+1: FIFO occupancy.

Function
REQ-003 Command FIFO shall push {cmd_rw,cmd_addr,cmd_wdata} when cmd_valid&cmd_ready; cmd_ready = (level != DEPTH).
REQ-004 FIFO pointers shall wrap modulo DEPTH; simultaneous push and pop shall leave level unchanged.
REQ-005 FSM states shall be IDLE, XFER, RESP.
REQ-006 IDLE with level>0 shall pop the head into registered rw/addr_in/data_in and go to XFER; IDLE with level=0 shall remain IDLE.
REQ-007 transfer shall be 1 exactly while in XFER; rw/addr_in/data_in shall be stable throughout XFER.
REQ-008 XFER with xfer_done=1 shall exit in that cycle:
- read: capture prdata into rsp_rdata, rsp_err=0, go to RESP.
- write: go to IDLE.
REQ-009 Timeout counter shall clear on XFER entry and increment each XFER cycle; if count==TIMEOUT-1 and xfer_done=0, the FSM shall abort:
- read: RESP with rsp_rdata=0, rsp_err=1.
- write: IDLE with no response.
REQ-010 xfer_done and timeout in the same cycle shall be treated as normal completion (done wins).
REQ-011 rsp_valid shall be 1 exactly in RESP; rsp_rdata and rsp_err shall hold until rsp_ready=1, then the FSM goes to IDLE.
REQ-012 Latency:
- handshake in cycle t into an empty FIFO with FSM IDLE -> transfer=1 in cycle t+2.
- xfer_done in cycle d -> transfer=0 in d+1, and a queued next command gives transfer=1 in d+2 (write) or r+2 (read, rsp_ready in cycle r).
REQ-013 xfer_done outside XFER shall be ignored; FIFO pushes shall continue during XFER/RESP.
REQ-014 Commands shall issue strictly in acceptance order; one outstanding transfer at most.

Reset
REQ-015 When presetn=0 at a rising pclk edge, the block shall reset:
- FSM to IDLE; FIFO emptied (level=0); timeout counter cleared.
- outputs: transfer=0, rw=0, addr_in=0, data_in=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, cmd_ready=0 during reset, 1 the cycle after release.
REQ-016 Reset mid-XFER or mid-RESP shall discard the in-flight command and response without emitting either.

Verification
REQ-017 Single write: cmd {rw=1,addr=0x10,wdata=0xA5A5A5A5} in cycle 0, xfer_done in cycle 4 -> transfer=1 cycles 2-4 with addr_in=0x10 and data_in=0xA5A5A5A5, transfer=0 in cycle 5, no rsp_valid.
REQ-018 Read with backpressure: read addr=0x20, prdata=0xDEADBEEF with xfer_done -> rsp_valid=1 with rsp_rdata=0xDEADBEEF, rsp_err=0, held 3 cycles while rsp_ready=0, cleared the cycle after rsp_ready=1.
REQ-019 Full FIFO: 6 back-to-back cmds with xfer_done=0 -> cmd_ready=0 once level=4; resume xfer_done -> all accepted commands issue in order, 0x0,0x4,... addresses.
REQ-020 Timeout: read with xfer_done never asserted -> transfer high exactly 16 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-021 Done-vs-timeout: xfer_done on the 16th XFER cycle with prdata=0x1234 -> rsp_err=0, rsp_rdata=0x1234.
REQ-022 Reset mid-XFER with level=2 -> cycle after reset: transfer=0, level=0, rsp_valid=0, busy=0.
